tetris_row_clear: RTL and testbench
===================================

Name: tetris_row_clear

Overview:
- Line-clear sequencer for the board SRAM (21 columns x 41 rows, 4-bit colour per cell, y=0 is the top row).
- The game control FSM pulses start after a piece locks. The block then holds the board SRAM port until it finishes.
- It scans rows from the bottom up, detects full rows, shifts every row above a full row down by one, and blanks row 0.
- It reports the number of cleared rows, then hands the SRAM port back to the control FSM.

Parameters:
- COLS, 21, board width in cells (x = 0..COLS-1).
- ROWS, 41, board height in cells (y = 0..ROWS-1).
- EMPTY, 4'd7, colour code of an empty (white) cell.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run a clear pass; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle (exclusive); the control FSM must not drive the SRAM while busy=1.
- done  output  1  one-cycle pulse when the pass completes.
- rows_cleared  output  3  full rows removed in the last pass; saturates at 7; held until the next start.
- sram_re  output  1  read strobe; data appears on sram_rdata on the next cycle.
- sram_we  output  1  write strobe; the cell is written at the clock edge.
- sram_x  output  5  cell column address.
- sram_y  output  6  cell row address.
- sram_wdata  output  4  write colour.
- sram_rdata  input  4  read colour, valid one cycle after sram_re.

Behaviour:
- Reset values: busy=0, done=0, rows_cleared=0, sram_re=0, sram_we=0, sram_x=0, sram_y=0, sram_wdata=EMPTY; state=IDLE.
- All sram_* outputs are decoded from registered state and counters (Moore style). At most one of re/we is high in any cycle.
- State IDLE: if start=1, then row=ROWS-1, x=0, rows_cleared=0, go to SCAN_RD. Otherwise stay.
- State SCAN_RD: re=1 at (x,row); go to SCAN_CHK.
- State SCAN_CHK: examine sram_rdata.
  - Colour == EMPTY: the row is not full. If row==0, go to DONE; else row-1, x=0, go to SCAN_RD.
  - Colour != EMPTY and x<COLS-1: x+1, go to SCAN_RD.
  - Colour != EMPTY and x==COLS-1: the row is full. rows_cleared+1 (saturating), dst=row, x=0. If row==0, go to TOP_WR; else go to SHIFT_RD.
- State SHIFT_RD: re=1 at (x,dst-1); go to SHIFT_WR.
- State SHIFT_WR: we=1 at (x,dst), wdata = sram_rdata captured from the read.
  - x<COLS-1: x+1, go to SHIFT_RD.
  - x==COLS-1 and dst>1: dst-1, x=0, go to SHIFT_RD.
  - x==COLS-1 and dst==1: x=0, go to TOP_WR.
- State TOP_WR: we=1 at (x,0), wdata=EMPTY. Once x==COLS-1, x=0 and go to SCAN_RD with row unchanged, so the shifted-in row is rescanned.
- State DONE: done=1, busy=0 for one cycle; go to IDLE.
- Cycle cost:
  - Scanning a full row costs 2*COLS cycles.
  - A full row at index r costs a further 2*COLS*r cycles (shift) plus COLS cycles (TOP_WR).
- start while busy: ignored; no queueing.
- Reset mid-pass: the block returns to IDLE immediately and all outputs take their reset values. Partially shifted board content is not repaired.
- Counter widths: x is 5 bits, row and dst are 6 bits. No arithmetic may wrap below 0; the row==0 and dst==1 checks above guard every decrement.

Optional Feature:
- Macro: TETRIS_ROWCLR_EMPTY_STOP_EN.
- Defined: in SCAN_CHK, if x==0 and the cell is EMPTY, a second flag tracks whether the row is entirely empty. Scanning continues across that row only while cells stay EMPTY. An all-EMPTY row goes straight to DONE, since no blocks can float above an empty row.
- Undefined: every row up to row 0 is scanned, with early abort on the first EMPTY cell as above.

Test Plan:
1. All cells EMPTY, start -> 41 rows x 2 cycles, each row aborting at x=0. Then done pulse with rows_cleared=0, no sram_we ever high, busy high exactly 82 cycles (feature off).
2. Row 40 all colour 3, cell (5,39)=2, rest EMPTY, start -> board afterwards has (5,40)=2 and all other cells EMPTY; rows_cleared=1; exactly 40*21 shift writes plus 21 top writes.
3. Rows 37..40 full (colours 1..4) -> rows_cleared=4, board all EMPTY. Row 40 is rescanned 4 times.
4. Rows 40 and 38 full, row 39 with only (0,39)=6 -> rows_cleared=2; (0,40)=6; rows 0..39 all EMPTY.
5. start pulsed again while busy=1 -> no effect on the count or on done timing. Reset asserted low during SHIFT_WR -> the next cycle shows busy=0, sram_we=0, rows_cleared=0.
6. Feature on, only row 40 full -> after the clear, row 40 rescan finds an all-EMPTY row and DONE follows. Feature off, the same board -> the scan continues to row 0 and DONE comes 40*2 cycles later.

Source files
------------

// File: rtl/tetris_row_clear_if.sv
// tetris_row_clear_if: start/busy/done handshake and board SRAM port of the row-clear sequencer
interface tetris_row_clear_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] rows_cleared;
  logic       sram_re;
  logic       sram_we;
  logic [4:0] sram_x;
  logic [5:0] sram_y;
  logic [3:0] sram_wdata;
  logic [3:0] sram_rdata;
  modport master(
    output start, sram_rdata,
    input  busy, done, rows_cleared, sram_re, sram_we, sram_x, sram_y, sram_wdata
  );
  modport slave(
    input  start, sram_rdata,
    output busy, done, rows_cleared, sram_re, sram_we, sram_x, sram_y, sram_wdata
  );
endinterface

// File: rtl/tetris_row_clear.sv
// tetris_row_clear: bottom-up full-row detect, shift-down and top-blank sequencer on the board SRAM (option TETRIS_ROWCLR_EMPTY_STOP_EN stops at an all-empty row)
module tetris_row_clear #(
  parameter int         COLS  = 21,
  parameter int         ROWS  = 41,
  parameter logic [3:0] EMPTY = 4'd7
) (
  input logic              clk,
  input logic              reset,
  tetris_row_clear_if.slave bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SCAN_RD  = 3'd1;
  localparam logic [2:0] SCAN_CHK = 3'd2;
  localparam logic [2:0] SHIFT_RD = 3'd3;
  localparam logic [2:0] SHIFT_WR = 3'd4;
  localparam logic [2:0] TOP_WR   = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;
  localparam logic [4:0] XL = 5'(COLS - 1);
  localparam logic [5:0] YL = 6'(ROWS - 1);
  logic [2:0] state;
  logic [4:0] x;
  logic [5:0] row;
  logic [5:0] dst;
  logic [2:0] cnt;
  logic       busy;
  logic       is_empty;
  logic       halt;
  logic       skip;
  assign is_empty = bus.sram_rdata == EMPTY;
`ifdef TETRIS_ROWCLR_EMPTY_STOP_EN
  logic blank;
  logic cont_blank;
  assign cont_blank = is_empty && (x == 5'd0 || blank);
  assign halt       = cont_blank && x == XL;
  assign skip       = !cont_blank && (is_empty || blank);
  always_ff @(posedge clk or negedge reset)
    if (!reset) blank <= 1'b0;
    else blank <= state == SCAN_CHK ? cont_blank : state == IDLE ? 1'b0 : blank;
`else
  assign halt = 1'b0;
  assign skip = is_empty;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      x     <= '0;
      row   <= '0;
      dst   <= '0;
      cnt   <= '0;
    end else
      case (state)
        IDLE:
          if (bus.start) begin
            row   <= YL;
            x     <= '0;
            cnt   <= '0;
            state <= SCAN_RD;
          end
        SCAN_RD: state <= SCAN_CHK;
        SCAN_CHK:
          if (halt || (skip && row == 6'd0)) state <= DONE;
          else if (skip) begin
            row   <= row - 6'd1;
            x     <= '0;
            state <= SCAN_RD;
          end else if (x != XL) begin
            x     <= x + 5'd1;
            state <= SCAN_RD;
          end else begin
            if (cnt != 3'd7) cnt <= cnt + 3'd1;
            dst   <= row;
            x     <= '0;
            state <= row == 6'd0 ? TOP_WR : SHIFT_RD;
          end
        SHIFT_RD: state <= SHIFT_WR;
        SHIFT_WR:
          if (x != XL) begin
            x     <= x + 5'd1;
            state <= SHIFT_RD;
          end else begin
            x <= '0;
            if (dst > 6'd1) begin
              dst   <= dst - 6'd1;
              state <= SHIFT_RD;
            end else state <= TOP_WR;
          end
        TOP_WR:
          if (x == XL) begin
            x     <= '0;
            state <= SCAN_RD;
          end else x <= x + 5'd1;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
  assign busy             = state != IDLE && state != DONE;
  assign bus.busy         = busy;
  assign bus.done         = state == DONE;
  assign bus.rows_cleared = cnt;
  assign bus.sram_re      = state == SCAN_RD || state == SHIFT_RD;
  assign bus.sram_we      = state == SHIFT_WR || state == TOP_WR;
  assign bus.sram_x       = busy ? x : '0;
  assign bus.sram_y       = (state == SCAN_RD || state == SCAN_CHK) ? row :
                            state == SHIFT_RD ? dst - 6'd1 :
                            state == SHIFT_WR ? dst : '0;
  assign bus.sram_wdata   = state == SHIFT_WR ? bus.sram_rdata : EMPTY;
endmodule

// File: tb/tb_tetris_row_clear.sv
// tb_tetris_row_clear: scoreboard bench with board SRAM model and abstract line-clear reference
module tb_tetris_row_clear;
  localparam int         COLS  = 21;
  localparam int         ROWS  = 41;
  localparam logic [3:0] EMPTY = 4'd7;
  typedef struct {
    int cnt;
    int cyc;
    int wr;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load = 1'b0;
  logic [3:0] mem [ROWS][COLS];
  logic [3:0] img [ROWS][COLS];
  logic [3:0] exp_b [ROWS][COLS];
  exp_t q[$];
  int compared = 0;
  int failed = 0;
  int n_done = 0;
  int busy_cyc = 0;
  int wr_cyc = 0;
  bit both = 1'b0;
  tetris_row_clear_if bus();
  tetris_row_clear #(.COLS(COLS), .ROWS(ROWS), .EMPTY(EMPTY)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (load)
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++)
          mem[y][x] <= img[y][x];
    if (bus.sram_re) bus.sram_rdata <= mem[bus.sram_y][bus.sram_x];
    if (bus.sram_we) mem[bus.sram_y][bus.sram_x] <= bus.sram_wdata;
  end
  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      busy_cyc = 0;
      wr_cyc = 0;
      both = 1'b0;
    end else begin
      if (bus.busy) busy_cyc++;
      if (bus.sram_we) wr_cyc++;
      if (bus.sram_re && bus.sram_we) both = 1'b1;
      if (bus.done) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_t e;
          int bad;
          e = q.pop_front();
          bad = 0;
          for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
              if (mem[y][x] !== exp_b[y][x]) bad++;
          check("rows_cleared", int'(bus.rows_cleared), e.cnt);
          check("busy_cycles", busy_cyc, e.cyc);
          check("write_count", wr_cyc, e.wr);
          check("re_we_exclusive", int'(both), 0);
          check("board_bad_cells", bad, 0);
        end
        busy_cyc = 0;
        wr_cyc = 0;
        both = 1'b0;
        n_done++;
      end
    end
  end
  // Reference: clear full rows bottom-up on a plain array, charging cycles by the cost rules.
  task automatic model(output exp_t e);
    int r, k, j;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        exp_b[y][x] = img[y][x];
    e.cnt = 0;
    e.cyc = 0;
    e.wr = 0;
    r = ROWS - 1;
    while (1) begin
      k = 0;
      while (k < COLS && exp_b[r][k] != EMPTY) k++;
      if (k == COLS) begin
        e.cnt++;
        e.cyc += 3 * COLS + 2 * COLS * r;
        e.wr += COLS * (r + 1);
        for (int y = r; y > 0; y--)
          for (int x = 0; x < COLS; x++)
            exp_b[y][x] = exp_b[y-1][x];
        for (int x = 0; x < COLS; x++) exp_b[0][x] = EMPTY;
        continue;
      end
`ifdef TETRIS_ROWCLR_EMPTY_STOP_EN
      if (k == 0) begin
        j = 0;
        while (j < COLS && exp_b[r][j] == EMPTY) j++;
        if (j == COLS) begin
          e.cyc += 2 * COLS;
          break;
        end
        e.cyc += 2 * (j + 1);
      end else
`endif
      e.cyc += 2 * (k + 1);
      if (r == 0) break;
      r--;
    end
    if (e.cnt > 7) e.cnt = 7;
  endtask
  function automatic logic [3:0] rcol();
    int c = $urandom_range(0, 14);
    return 4'(c >= 7 ? c + 1 : c);
  endfunction
  task automatic clear_img();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        img[y][x] = EMPTY;
  endtask
  task automatic fill_row(input int y, input logic [3:0] c);
    for (int x = 0; x < COLS; x++) img[y][x] = c;
  endtask
  task automatic load_board();
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask
  task automatic run_pass(input bit extra_start);
    exp_t e;
    int target;
    load_board();
    model(e);
    q.push_back(e);
    target = n_done + 1;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (extra_start) begin
      repeat (50) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    for (int i = 0; i < 40000 && n_done < target; i++) @(posedge clk);
    if (n_done < target) begin
      check("done_timeout", n_done, target);
      q.delete();
    end
  endtask
  initial begin
    int h;
    bit full;
    bus.start = 1'b0;
    clear_img();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_rows_cleared", int'(bus.rows_cleared), 0);
    check("rst_re", int'(bus.sram_re), 0);
    check("rst_we", int'(bus.sram_we), 0);
    check("rst_x", int'(bus.sram_x), 0);
    check("rst_y", int'(bus.sram_y), 0);
    check("rst_wdata", int'(bus.sram_wdata), int'(EMPTY));
    reset = 1'b1;
    clear_img();
    run_pass(1'b0);
    clear_img();
    fill_row(40, 4'd3);
    img[39][5] = 4'd2;
    run_pass(1'b0);
    clear_img();
    for (int i = 0; i < 4; i++) fill_row(37 + i, 4'(i + 1));
    run_pass(1'b0);
    clear_img();
    fill_row(40, 4'd5);
    fill_row(38, 4'd9);
    img[39][0] = 4'd6;
    run_pass(1'b0);
    clear_img();
    for (int y = 32; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        img[y][x] = rcol();
    img[31][3] = 4'd1;
    run_pass(1'b0);
    clear_img();
    fill_row(40, 4'd3);
    img[39][5] = 4'd2;
    run_pass(1'b1);
    clear_img();
    fill_row(40, 4'd12);
    fill_row(39, 4'd1);
    load_board();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < 5000 && !(bus.sram_we && bus.sram_y != 6'd0); i++) @(negedge clk);
    check("reach_shift_wr", int'(bus.sram_we && bus.sram_y != 6'd0), 1);
    check("pre_reset_rows_cleared", int'(bus.rows_cleared), 1);
    reset = 1'b0;
    q.delete();
    @(posedge clk); #1;
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_we", int'(bus.sram_we), 0);
    check("midreset_re", int'(bus.sram_re), 0);
    check("midreset_rows_cleared", int'(bus.rows_cleared), 0);
    reset = 1'b1;
    for (int p = 0; p < 4; p++) begin
      h = $urandom_range(2, 5);
      clear_img();
      for (int y = 0; y < ROWS; y++)
        if (y >= ROWS - h) begin
          full = $urandom_range(0, 2) == 0;
          for (int x = 0; x < COLS; x++)
            img[y][x] = (full || $urandom_range(0, 3) != 0) ? rcol() : EMPTY;
        end else if ($urandom_range(0, 5) == 0)
          img[y][$urandom_range(0, COLS - 1)] = rcol();
      run_pass(1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
